// File: rtl/seg_scan_if.sv
// seg_scan_if: value inputs and display pins of the multiplexed 7-segment scanner
interface seg_scan_if #(
  parameter int DIGITS = 6
);
  localparam int SEL_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  logic [4*DIGITS-1:0] data_in;
  logic [DIGITS-1:0]   dp_in;
  logic [DIGITS-1:0]   blank_in;
  logic [7:0]          seg;
  logic [SEL_W-1:0]    sel;
  logic                frame_done;
  modport master (output data_in, dp_in, blank_in, input seg, sel, frame_done);
  modport slave (input data_in, dp_in, blank_in, output seg, sel, frame_done);
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed hex 7-segment scanner with dead time and frame capture; SEG_LZ_BLANK_EN adds leading-zero suppression
module seg_scan_ctrl #(
  parameter int CLK_HZ         = 50_000_000,
  parameter int SCAN_HZ        = 1000,
  parameter int DIGITS         = 6,
  parameter int BLANK_CYC      = 2,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input logic       clk,
  input logic       rst_n,
  seg_scan_if.slave bus
);
  localparam int TICK  = CLK_HZ / SCAN_HZ;
  localparam int CW    = (TICK > 1) ? $clog2(TICK) : 1;
  localparam int SEL_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [7:0] POL = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [16*7-1:0] SEG_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  logic [CW-1:0]       r_cnt;
  logic [SEL_W-1:0]    r_sel;
  logic [3:0]          r_blank_cnt;
  logic [4*DIGITS-1:0] r_data;
  logic [DIGITS-1:0]   r_dp;
  logic [DIGITS-1:0]   r_blank;
  logic [7:0]          r_seg;
  logic                r_frame_done;
  logic                w_tick;
  logic                w_wrap;
  logic [SEL_W-1:0]    w_sel_nxt;
  logic [SEL_W-1:0]    w_idx;
  logic [3:0]          w_blank_nxt;
  logic [3:0]          w_nib;
  logic [7:0]          w_seg_hi;
  logic [DIGITS-1:0]   w_lz;
  assign w_tick      = r_cnt == CW'(TICK - 1);
  assign w_wrap      = w_tick && r_sel == SEL_W'(DIGITS - 1);
  assign w_sel_nxt   = w_wrap ? '0 : r_sel + SEL_W'(w_tick);
  assign w_blank_nxt = w_tick ? 4'(BLANK_CYC) : r_blank_cnt - 4'(r_blank_cnt != 4'd0);
  assign w_idx       = SEL_W'(DIGITS - 1) - r_sel;
  assign w_nib       = r_data[{w_idx, 2'b00} +: 4];
  // Dead time is judged on the upcoming count so the tick edge itself already drives OFF alongside the new sel
  assign w_seg_hi    = (w_blank_nxt != 4'd0 || r_blank[w_idx]) ? 8'h00 : {r_dp[w_idx], SEG_LUT[7*w_nib +: 7]};
`ifdef SEG_LZ_BLANK_EN
  logic w_lz_run;
  // Blank zero digits from the left until a nonzero nibble or a lit dp; the last digit always shows
  always_comb begin
    w_lz     = '0;
    w_lz_run = 1'b1;
    for (int i = 0; i < DIGITS - 1; i++) begin
      w_lz_run = w_lz_run && bus.data_in[4*(DIGITS-1-i) +: 4] == 4'h0 && !bus.dp_in[DIGITS-1-i];
      w_lz[DIGITS-1-i] = w_lz_run;
    end
  end
`else
  assign w_lz = '0;
`endif
  // Prescaler, digit select, dead-time counter and frame pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_sel        <= '0;
      r_blank_cnt  <= 4'(BLANK_CYC);
      r_frame_done <= 1'b0;
    end else begin
      r_cnt        <= w_tick ? '0 : r_cnt + 1'b1;
      r_sel        <= w_sel_nxt;
      r_blank_cnt  <= w_blank_nxt;
      r_frame_done <= w_wrap;
    end
  end
  // Shadow registers load only at the frame boundary so a frame is always coherent
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_dp    <= '0;
      r_blank <= '1;
    end else if (w_wrap) begin
      r_data  <= bus.data_in;
      r_dp    <= bus.dp_in;
      r_blank <= bus.blank_in | w_lz;
    end
  end
  // Registered segment bus with output polarity applied
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_seg <= POL;
    else r_seg <= w_seg_hi ^ POL;
  end
  assign bus.seg        = r_seg;
  assign bus.sel        = r_sel;
  assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl (TICK=8, DIGITS=4, BLANK_CYC=2)
module tb_seg_scan_ctrl;
  typedef struct {
    logic [1:0] sel;
    logic [7:0] seg;
    logic       fd;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t q[$];
  exp_t e;
  bit   ok;
  seg_scan_if #(.DIGITS(4)) bus ();
  seg_scan_if #(.DIGITS(4)) bus_ah ();
  seg_scan_ctrl #(.CLK_HZ(16), .SCAN_HZ(2), .DIGITS(4), .BLANK_CYC(2), .SEG_ACTIVE_LOW(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  seg_scan_ctrl #(.CLK_HZ(16), .SCAN_HZ(2), .DIGITS(4), .BLANK_CYC(2), .SEG_ACTIVE_LOW(0)) u_dut_ah (
    .clk(clk), .rst_n(rst_n), .bus(bus_ah));
  always #5 clk = ~clk;
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction
  function automatic logic [3:0] lz_model(input logic [15:0] d, input logic [3:0] dp);
    logic [3:0] b = 4'b0000;
`ifdef SEG_LZ_BLANK_EN
    for (int i = 0; i < 3; i++) begin
      if (d[15-4*i -: 4] != 4'h0 || dp[3-i]) break;
      b[3-i] = 1'b1;
    end
`endif
    return b;
  endfunction
  task automatic push_frame(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl, input bit ah);
    logic [3:0] eb;
    logic [7:0] hi;
    exp_t x;
    eb = bl | lz_model(d, dp);
    for (int i = 0; i < 4; i++)
      for (int c = 0; c < 8; c++) begin
        hi = (c < 2 || eb[3-i]) ? 8'h00 : {dp[3-i], glyph(d[15-4*i -: 4])};
        x.sel = 2'(i);
        x.seg = ah ? hi : ~hi;
        x.fd  = (i == 0 && c == 0);
        q.push_back(x);
      end
  endtask
  task automatic wait_frame(output bit found);
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.frame_done === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask
  task automatic set_in(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    bus.data_in  = d;
    bus.dp_in    = dp;
    bus.blank_in = bl;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.sel !== 2'd0 || bus.seg !== 8'hFF || bus.frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state sel=%0d seg=%h fd=%b expected sel=0 seg=ff fd=0", bus.sel, bus.seg, bus.frame_done);
    end
    rst_n = 1'b1;
    for (int k = 1; k < 32; k++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.seg !== 8'hFF || bus.frame_done !== 1'b0 || bus.sel !== 2'(k / 8)) begin
        n_err++;
        $display("FAIL startup_dark edge=%0d sel=%0d seg=%h fd=%b expected sel=%0d seg=ff fd=0", k, bus.sel, bus.seg, bus.frame_done, k / 8);
      end
    end
    @(negedge clk);
    push_frame(16'h12AF, 4'b0000, 4'b0000, 1'b0);
    for (int k = 0; k < 32; k++) begin
      e = q.pop_front();
      n_cmp++;
      if (bus.sel !== e.sel || bus.seg !== e.seg || bus.frame_done !== e.fd) begin
        n_err++;
        $display("FAIL first_frame k=%0d sel=%0d seg=%h fd=%b expected sel=%0d seg=%h fd=%b", k, bus.sel, bus.seg, bus.frame_done, e.sel, e.seg, e.fd);
      end
      @(negedge clk);
    end
  endtask
  task automatic test_mid_frame();
    set_in(16'h12AF, 4'b0000, 4'b0000);
    wait_frame(ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_err++;
      $display("FAIL mid_frame_wait frame_done=0 expected 1 within 40 clocks");
    end
    push_frame(16'h12AF, 4'b0000, 4'b0000, 1'b0);
    push_frame(16'h0000, 4'b0000, 4'b0000, 1'b0);
    for (int k = 0; k < 64; k++) begin
      if (k == 8) bus.data_in = 16'h0000;
      e = q.pop_front();
      n_cmp++;
      if (bus.sel !== e.sel || bus.seg !== e.seg || bus.frame_done !== e.fd) begin
        n_err++;
        $display("FAIL mid_frame k=%0d sel=%0d seg=%h fd=%b expected sel=%0d seg=%h fd=%b", k, bus.sel, bus.seg, bus.frame_done, e.sel, e.seg, e.fd);
      end
      @(negedge clk);
    end
  endtask
  task automatic test_dp_blank();
    set_in(16'h12AF, 4'b0100, 4'b0001);
    wait_frame(ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_err++;
      $display("FAIL dp_blank_wait frame_done=0 expected 1 within 40 clocks");
    end
    push_frame(16'h12AF, 4'b0100, 4'b0001, 1'b0);
    for (int k = 0; k < 32; k++) begin
      e = q.pop_front();
      n_cmp++;
      if (bus.sel !== e.sel || bus.seg !== e.seg || bus.frame_done !== e.fd) begin
        n_err++;
        $display("FAIL dp_blank k=%0d sel=%0d seg=%h fd=%b expected sel=%0d seg=%h fd=%b", k, bus.sel, bus.seg, bus.frame_done, e.sel, e.seg, e.fd);
      end
      @(negedge clk);
    end
  endtask
  task automatic test_leading_zero();
    logic [15:0] pat [2];
    pat[0] = 16'h0030;
    pat[1] = 16'h0000;
    for (int p = 0; p < 2; p++) begin
      set_in(pat[p], 4'b0000, 4'b0000);
      wait_frame(ok);
      n_cmp++;
      if (ok !== 1'b1) begin
        n_err++;
        $display("FAIL lz_wait frame_done=0 expected 1 within 40 clocks");
      end
      push_frame(pat[p], 4'b0000, 4'b0000, 1'b0);
      for (int k = 0; k < 32; k++) begin
        e = q.pop_front();
        n_cmp++;
        if (bus.sel !== e.sel || bus.seg !== e.seg || bus.frame_done !== e.fd) begin
          n_err++;
          $display("FAIL leading_zero data=%h k=%0d sel=%0d seg=%h fd=%b expected sel=%0d seg=%h fd=%b", pat[p], k, bus.sel, bus.seg, bus.frame_done, e.sel, e.seg, e.fd);
        end
        @(negedge clk);
      end
    end
  endtask
  task automatic test_mid_reset();
    set_in(16'h12AF, 4'b0000, 4'b0000);
    wait_frame(ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset_wait frame_done=0 expected 1 within 40 clocks");
    end
    repeat (21) @(negedge clk);
    n_cmp++;
    if (bus.sel !== 2'd2) begin
      n_err++;
      $display("FAIL mid_reset_pos sel=%0d expected 2", bus.sel);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.sel !== 2'd0 || bus.seg !== 8'hFF || bus.frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset sel=%0d seg=%h fd=%b expected sel=0 seg=ff fd=0", bus.sel, bus.seg, bus.frame_done);
    end
    test_reset();
  endtask
  task automatic test_active_high();
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      ok = bus_ah.frame_done === 1'b1;
    end
    n_cmp++;
    if (ok !== 1'b1) begin
      n_err++;
      $display("FAIL active_high_wait frame_done=0 expected 1 within 40 clocks");
    end
    push_frame(16'h8888, 4'b0000, 4'b0000, 1'b1);
    for (int k = 0; k < 32; k++) begin
      e = q.pop_front();
      n_cmp++;
      if (bus_ah.sel !== e.sel || bus_ah.seg !== e.seg || bus_ah.frame_done !== e.fd) begin
        n_err++;
        $display("FAIL active_high k=%0d sel=%0d seg=%h fd=%b expected sel=%0d seg=%h fd=%b", k, bus_ah.sel, bus_ah.seg, bus_ah.frame_done, e.sel, e.seg, e.fd);
      end
      @(negedge clk);
    end
  endtask
  initial begin
    set_in(16'h12AF, 4'b0000, 4'b0000);
    bus_ah.data_in  = 16'h8888;
    bus_ah.dp_in    = 4'b0000;
    bus_ah.blank_in = 4'b0000;
    test_reset();
    test_mid_frame();
    test_dp_blank();
    test_leading_zero();
    test_mid_reset();
    test_active_high();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
